mc_controller: RTL and testbench
================================

// Module: mc_controller
// PURPOSE
//  Multicycle main controller for the 6+1-instruction MIPS core (addu, subu, ori, lw, sw, beq, j).
//  Decodes op/funct and sequences a shared-ALU, shared-memory datapath through fetch/decode/execute/mem/writeback.
//  Drives all datapath mux selects and write enables, plus a req/ack memory handshake with timeout.
//  Keeps a retired-instruction counter.
// PARAMETERS
//  MEM_TO   16  cycles mem_req may stay high without mem_ack before abort; 0 disables timeout
//  CNT_W    32  width of instr_count
// PORTS
//  clk          in   1      clock, rising edge
//  rst          in   1      asynchronous, active-low reset
//  op           in   6      instr[31:26] from IR
//  funct        in   6      instr[5:0] from IR
//  zero         in   1      ALU zero flag
//  mem_ack      in   1      memory completes current request this cycle
//  mem_req      out  1      memory access request
//  mem_we       out  1      1=write (valid with mem_req)
//  iord         out  1      address mux: 0=PC, 1=ALUOut
//  irwrite      out  1      load IR
//  pcen         out  1      PC write enable (pcwrite | branch&zero)
//  pcsrc        out  2      00=ALU result, 01=ALUOut, 10=jump target
//  alusrca      out  1      0=PC, 1=reg A
//  alusrcb      out  2      00=reg B, 01=const 4, 10=ext imm, 11=signimm<<2
//  ext_zero     out  1      immediate extender: 1=zero-extend, 0=sign-extend
//  alucontrol   out  3      010 add, 110 sub, 001 or
//  regdst       out  1      0=rt, 1=rd
//  memtoreg     out  1      0=ALUOut, 1=memory data reg
//  regwrite     out  1      register file write enable
//  illegal_op   out  1      1-cycle pulse: unsupported op/funct decoded
//  mem_err      out  1      1-cycle pulse: memory timeout abort
//  instr_done   out  1      1-cycle pulse: instruction retired
//  instr_count  out  CNT_W  retired instructions, wraps at 2^CNT_W
// BEHAVIOUR
//  - rst low: state=IDLE; all outputs 0; instr_count=0; timeout counter=0. Async assert, mid-instruction included (in-flight access dropped).
//  - IDLE -> FETCH unconditionally on first edge after release.
//  - Outputs decode from state (Moore), except irwrite/pcen in FETCH, which are gated by mem_ack (Mealy).
//  - Unlisted outputs are 0 in each state.
//  - FETCH:   mem_req=1, iord=0, alusrca=0, alusrcb=01, add, pcsrc=00; on mem_ack: irwrite=1, pcen=1 -> DECODE; else stay.
//  - DECODE:  alusrca=0, alusrcb=11, add (branch target into ALUOut).
//             op 100011/101011 -> MEMADR; 000000 -> RTYPEEX; 001101 -> ORIEX; 000100 -> BEQ; 000010 -> JUMP;
//             other -> illegal_op pulse, FETCH.
//  - MEMADR:  alusrca=1, alusrcb=10, ext_zero=0, add; lw -> MEMRD, sw -> MEMWR.
//  - MEMRD:   mem_req=1, iord=1; ack -> MEMWB.  MEMWR: mem_req=1, mem_we=1, iord=1; ack -> FETCH, retire.
//  - MEMWB:   regdst=0, memtoreg=1, regwrite=1 -> FETCH, retire.
//  - RTYPEEX: alusrca=1, alusrcb=00; funct 100001 -> 010, 100011 -> 110 -> RTYPEWB;
//             other -> illegal_op, FETCH, no write.
//  - RTYPEWB: regdst=1, regwrite=1 -> FETCH, retire.
//  - ORIEX:   alusrca=1, alusrcb=10, ext_zero=1, alucontrol=001 -> ORIWB.  ORIWB: regdst=0, regwrite=1 -> FETCH, retire.
//  - BEQ:     alusrca=1, alusrcb=00, sub, pcsrc=01, pcen=zero -> FETCH, retire.
//  - JUMP:    pcsrc=10, pcen=1 -> FETCH, retire.
//  - Latency, zero-wait memory: beq/j 3, addu/subu/ori/sw 4, lw 5 cycles.
//  - Retire: instr_done=1 and instr_count+1 on the cycle leaving the final state.
//  - Handshake: mem_req held high and mem_we/iord held stable until mem_ack sampled high. mem_ack while mem_req=0 is ignored.
//  - Timeout (MEM_TO>0): counter increments each cycle mem_req=1 and mem_ack=0; clears on ack or state change.
//    Reaching MEM_TO -> mem_err pulse, mem_req drops, next state FETCH; no retire, no regwrite.
//    Aborted FETCH leaves PC unchanged (retry). mem_ack in the abort cycle is ignored.
//  - Encoding: states are one-hot or binary; unreachable encodings -> FETCH next cycle, outputs 0.
// TESTING
//  1. rst low 3 cycles, release; mem_ack tied 1 -> IDLE, then FETCH with mem_req=1, irwrite=pcen=1 on 2nd edge after release.
//  2. addu (op 000000, funct 100001), zero-wait -> 4 cycles; alucontrol=010 in RTYPEEX; regdst=1, regwrite=1 once; instr_count 0->1.
//  3. lw, mem_ack delayed 3 cycles in MEMRD -> mem_req/iord held 3 cycles; MEMWB memtoreg=1, regwrite=1; total 8 cycles.
//  4. beq with zero=1 then zero=0 -> pcen=1 / 0 in BEQ, pcsrc=01 both; each retires in 3 cycles.
//  5. op 111111, then funct 000000 -> illegal_op pulse, no regwrite, no retire, back to FETCH.
//  6. MEM_TO=16, sw, mem_ack never -> mem_err at 16th waiting cycle, mem_req low next, FETCH; rst low mid-MEMWR -> IDLE, all outputs 0 at once.

Source files
------------

// File: rtl/mc_controller.sv
// mc_controller: multicycle main controller for the addu/subu/ori/lw/sw/beq/j core.
// Sequences a shared ALU and memory with req/ack handshake, timeout and retire count.
module mc_controller #(
  parameter int MEM_TO = 16,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             irwrite,
  output logic             pcen,
  output logic [1:0]       pcsrc,
  output logic             alusrca,
  output logic [1:0]       alusrcb,
  output logic             ext_zero,
  output logic [2:0]       alucontrol,
  output logic             regdst,
  output logic             memtoreg,
  output logic             regwrite,
  output logic             illegal_op,
  output logic             mem_err,
  output logic             instr_done,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEMADR  = 4'd3,
    S_MEMRD   = 4'd4,
    S_MEMWR   = 4'd5,
    S_MEMWB   = 4'd6,
    S_RTYPEEX = 4'd7,
    S_RTYPEWB = 4'd8,
    S_ORIEX   = 4'd9,
    S_ORIWB   = 4'd10,
    S_BEQ     = 4'd11,
    S_JUMP    = 4'd12
  } state_t;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_ORI = 6'b001101;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUBU = 6'b100011;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_OR  = 3'b001;

  localparam int TW = (MEM_TO > 0) ? $clog2(MEM_TO + 1) : 1;

  state_t        state;
  state_t        nxt;
  logic [TW-1:0] tcnt;
  logic          is_req;
  logic          abort;
  logic          ack;

  assign is_req = (state == S_FETCH) || (state == S_MEMRD) ||
                  (state == S_MEMWR);
  // the abort cycle itself has mem_req low, so any ack there is dropped
  assign abort  = (MEM_TO > 0) && is_req && (tcnt == TW'(MEM_TO));
  assign ack    = is_req && !abort && mem_ack;

  always_comb begin
    nxt        = state;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    irwrite    = 1'b0;
    pcen       = 1'b0;
    pcsrc      = 2'b00;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    ext_zero   = 1'b0;
    alucontrol = 3'b000;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite   = 1'b0;
    illegal_op = 1'b0;
    mem_err    = 1'b0;
    instr_done = 1'b0;
    case (state)
      S_IDLE: nxt = S_FETCH;
      S_FETCH: begin
        mem_req    = !abort;
        alusrcb    = 2'b01;
        alucontrol = ALU_ADD;
        if (abort) begin
          mem_err = 1'b1;
          nxt     = S_FETCH;
        end else if (ack) begin
          irwrite = 1'b1;
          pcen    = 1'b1;
          nxt     = S_DECODE;
        end
      end
      S_DECODE: begin
        alusrcb    = 2'b11;
        alucontrol = ALU_ADD;
        case (op)
          OP_LW, OP_SW: nxt = S_MEMADR;
          OP_R:         nxt = S_RTYPEEX;
          OP_ORI:       nxt = S_ORIEX;
          OP_BEQ:       nxt = S_BEQ;
          OP_J:         nxt = S_JUMP;
          default: begin
            illegal_op = 1'b1;
            nxt        = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        alucontrol = ALU_ADD;
        nxt        = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_req = !abort;
        iord    = 1'b1;
        if (abort) begin
          mem_err = 1'b1;
          nxt     = S_FETCH;
        end else if (ack) begin
          nxt = S_MEMWB;
        end
      end
      S_MEMWR: begin
        mem_req = !abort;
        mem_we  = !abort;
        iord    = 1'b1;
        if (abort) begin
          mem_err = 1'b1;
          nxt     = S_FETCH;
        end else if (ack) begin
          instr_done = 1'b1;
          nxt        = S_FETCH;
        end
      end
      S_MEMWB: begin
        memtoreg   = 1'b1;
        regwrite   = 1'b1;
        instr_done = 1'b1;
        nxt        = S_FETCH;
      end
      S_RTYPEEX: begin
        alusrca = 1'b1;
        case (funct)
          F_ADDU: begin
            alucontrol = ALU_ADD;
            nxt        = S_RTYPEWB;
          end
          F_SUBU: begin
            alucontrol = ALU_SUB;
            nxt        = S_RTYPEWB;
          end
          default: begin
            illegal_op = 1'b1;
            nxt        = S_FETCH;
          end
        endcase
      end
      S_RTYPEWB: begin
        regdst     = 1'b1;
        regwrite   = 1'b1;
        instr_done = 1'b1;
        nxt        = S_FETCH;
      end
      S_ORIEX: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        ext_zero   = 1'b1;
        alucontrol = ALU_OR;
        nxt        = S_ORIWB;
      end
      S_ORIWB: begin
        regwrite   = 1'b1;
        instr_done = 1'b1;
        nxt        = S_FETCH;
      end
      S_BEQ: begin
        alusrca    = 1'b1;
        alucontrol = ALU_SUB;
        pcsrc      = 2'b01;
        pcen       = zero;
        instr_done = 1'b1;
        nxt        = S_FETCH;
      end
      S_JUMP: begin
        pcsrc      = 2'b10;
        pcen       = 1'b1;
        instr_done = 1'b1;
        nxt        = S_FETCH;
      end
      default: nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      tcnt        <= '0;
      instr_count <= '0;
    end else begin
      state <= nxt;
      if ((MEM_TO > 0) && is_req && !abort && !mem_ack)
        tcnt <= tcnt + TW'(1);
      else
        tcnt <= '0;
      if (instr_done)
        instr_count <= instr_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: directed per-scenario checks of the multicycle controller.
// Control outputs are compared as one packed vector per cycle.
module tb_mc_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic        zero;
  logic        mem_ack;
  logic        mem_req, mem_we, iord, irwrite, pcen;
  logic [1:0]  pcsrc;
  logic        alusrca;
  logic [1:0]  alusrcb;
  logic        ext_zero;
  logic [2:0]  alucontrol;
  logic        regdst, memtoreg, regwrite;
  logic        illegal_op, mem_err, instr_done;
  logic [31:0] instr_count;
  logic [19:0] ctl;

  int passed = 0;
  int total  = 0;

  // {req,we,iord,irw,pcen}_{pcsrc}_{srca,srcb}_{ext}_{aluc}_{rdst,m2r,rw}_{ill,err,done}
  localparam logic [19:0] V_ZERO  = 20'b00000_00_000_0_000_000_000;
  localparam logic [19:0] V_FETCH = 20'b10011_00_001_0_010_000_000;
  localparam logic [19:0] V_DEC   = 20'b00000_00_011_0_010_000_000;
  localparam logic [19:0] V_DECIL = 20'b00000_00_011_0_010_000_100;
  localparam logic [19:0] V_ADDU  = 20'b00000_00_100_0_010_000_000;
  localparam logic [19:0] V_SUBU  = 20'b00000_00_100_0_110_000_000;
  localparam logic [19:0] V_RIL   = 20'b00000_00_100_0_000_000_100;
  localparam logic [19:0] V_RWB   = 20'b00000_00_000_0_000_101_001;
  localparam logic [19:0] V_MADR  = 20'b00000_00_110_0_010_000_000;
  localparam logic [19:0] V_MRD   = 20'b10100_00_000_0_000_000_000;
  localparam logic [19:0] V_MWB   = 20'b00000_00_000_0_000_011_001;
  localparam logic [19:0] V_MWRW  = 20'b11100_00_000_0_000_000_000;
  localparam logic [19:0] V_MWRA  = 20'b11100_00_000_0_000_000_001;
  localparam logic [19:0] V_ABRT  = 20'b00100_00_000_0_000_000_010;
  localparam logic [19:0] V_BEQ1  = 20'b00001_01_100_0_110_000_001;
  localparam logic [19:0] V_BEQ0  = 20'b00000_01_100_0_110_000_001;
  localparam logic [19:0] V_JUMP  = 20'b00001_10_000_0_000_000_001;
  localparam logic [19:0] V_ORIEX = 20'b00000_00_110_1_001_000_000;
  localparam logic [19:0] V_ORIWB = 20'b00000_00_000_0_000_001_001;

  assign ctl = {mem_req, mem_we, iord, irwrite, pcen, pcsrc, alusrca,
                alusrcb, ext_zero, alucontrol, regdst, memtoreg,
                regwrite, illegal_op, mem_err, instr_done};

  mc_controller #(.MEM_TO(16), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero),
    .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we),
    .iord(iord), .irwrite(irwrite), .pcen(pcen), .pcsrc(pcsrc),
    .alusrca(alusrca), .alusrcb(alusrcb), .ext_zero(ext_zero),
    .alucontrol(alucontrol), .regdst(regdst), .memtoreg(memtoreg),
    .regwrite(regwrite), .illegal_op(illegal_op), .mem_err(mem_err),
    .instr_done(instr_done), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0; mem_ack = 1'b1; op = '0; funct = '0; zero = 1'b0;
    repeat (3) tick;
    total++;
    if (ctl !== V_ZERO) $display("FAIL reset_ctl got %b exp %b", ctl, V_ZERO);
    else passed++;
    total++;
    if (instr_count !== 32'd0) $display("FAIL reset_cnt got %0d exp 0", instr_count);
    else passed++;
    rst = 1'b1;
    #1;
    total++;
    if (ctl !== V_ZERO) $display("FAIL idle_ctl got %b exp %b", ctl, V_ZERO);
    else passed++;
    tick;
    total++;
    if (ctl !== V_FETCH) $display("FAIL first_fetch got %b exp %b", ctl, V_FETCH);
    else passed++;
  endtask

  task automatic test_rtype(input logic [5:0] f, input logic [19:0] vex,
                            input int cnt);
    op = 6'b000000; funct = f;
    tick;
    total++;
    if (ctl !== V_DEC) $display("FAIL r_decode got %b exp %b", ctl, V_DEC);
    else passed++;
    tick;
    total++;
    if (ctl !== vex) $display("FAIL r_ex got %b exp %b", ctl, vex);
    else passed++;
    tick;
    total++;
    if (ctl !== V_RWB) $display("FAIL r_wb got %b exp %b", ctl, V_RWB);
    else passed++;
    tick;
    total++;
    if ({ctl, instr_count} !== {V_FETCH, 32'(cnt)})
      $display("FAIL r_retire got %b/%0d exp %b/%0d", ctl, instr_count, V_FETCH, cnt);
    else passed++;
  endtask

  task automatic test_lw_wait;
    op = 6'b100011;
    tick;
    tick;
    total++;
    if (ctl !== V_MADR) $display("FAIL lw_madr got %b exp %b", ctl, V_MADR);
    else passed++;
    mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      total++;
      if (ctl !== V_MRD) $display("FAIL lw_wait%0d got %b exp %b", i, ctl, V_MRD);
      else passed++;
    end
    tick;
    mem_ack = 1'b1;
    #1;
    total++;
    if (ctl !== V_MRD) $display("FAIL lw_ackcyc got %b exp %b", ctl, V_MRD);
    else passed++;
    tick;
    total++;
    if (ctl !== V_MWB) $display("FAIL lw_wb got %b exp %b", ctl, V_MWB);
    else passed++;
    tick;
    total++;
    if ({ctl, instr_count} !== {V_FETCH, 32'd3})
      $display("FAIL lw_retire got %b/%0d exp %b/3", ctl, instr_count, V_FETCH);
    else passed++;
  endtask

  task automatic test_beq(input logic z, input logic [19:0] vb, input int cnt);
    op = 6'b000100; zero = z;
    tick;
    tick;
    total++;
    if (ctl !== vb) $display("FAIL beq_z%0d got %b exp %b", z, ctl, vb);
    else passed++;
    tick;
    total++;
    if ({ctl, instr_count} !== {V_FETCH, 32'(cnt)})
      $display("FAIL beq_retire got %b/%0d exp %b/%0d", ctl, instr_count, V_FETCH, cnt);
    else passed++;
  endtask

  task automatic test_illegal;
    op = 6'b111111;
    tick;
    total++;
    if (ctl !== V_DECIL) $display("FAIL ill_op got %b exp %b", ctl, V_DECIL);
    else passed++;
    tick;
    total++;
    if ({ctl, instr_count} !== {V_FETCH, 32'd5})
      $display("FAIL ill_op_back got %b/%0d exp %b/5", ctl, instr_count, V_FETCH);
    else passed++;
    op = 6'b000000; funct = 6'b000000;
    tick;
    tick;
    total++;
    if (ctl !== V_RIL) $display("FAIL ill_funct got %b exp %b", ctl, V_RIL);
    else passed++;
    tick;
    total++;
    if ({ctl, instr_count} !== {V_FETCH, 32'd5})
      $display("FAIL ill_funct_back got %b/%0d exp %b/5", ctl, instr_count, V_FETCH);
    else passed++;
  endtask

  task automatic test_jump_ori;
    op = 6'b000010;
    tick;
    tick;
    total++;
    if (ctl !== V_JUMP) $display("FAIL jump got %b exp %b", ctl, V_JUMP);
    else passed++;
    tick;
    op = 6'b001101;
    tick;
    tick;
    total++;
    if (ctl !== V_ORIEX) $display("FAIL ori_ex got %b exp %b", ctl, V_ORIEX);
    else passed++;
    tick;
    total++;
    if (ctl !== V_ORIWB) $display("FAIL ori_wb got %b exp %b", ctl, V_ORIWB);
    else passed++;
    tick;
    total++;
    if ({ctl, instr_count} !== {V_FETCH, 32'd7})
      $display("FAIL ori_retire got %b/%0d exp %b/7", ctl, instr_count, V_FETCH);
    else passed++;
  endtask

  task automatic test_sw;
    op = 6'b101011;
    tick;
    tick;
    tick;
    total++;
    if (ctl !== V_MWRA) $display("FAIL sw_wr got %b exp %b", ctl, V_MWRA);
    else passed++;
    tick;
    total++;
    if ({ctl, instr_count} !== {V_FETCH, 32'd8})
      $display("FAIL sw_retire got %b/%0d exp %b/8", ctl, instr_count, V_FETCH);
    else passed++;
  endtask

  task automatic test_timeout;
    op = 6'b101011;
    tick;
    tick;
    mem_ack = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick;
      total++;
      if (ctl !== V_MWRW) $display("FAIL to_wait%0d got %b exp %b", i, ctl, V_MWRW);
      else passed++;
    end
    tick;
    mem_ack = 1'b1;
    #1;
    total++;
    if (ctl !== V_ABRT) $display("FAIL to_abort got %b exp %b", ctl, V_ABRT);
    else passed++;
    tick;
    total++;
    if ({ctl, instr_count} !== {V_FETCH, 32'd8})
      $display("FAIL to_refetch got %b/%0d exp %b/8", ctl, instr_count, V_FETCH);
    else passed++;
  endtask

  task automatic test_reset_mid;
    op = 6'b101011;
    tick;
    tick;
    mem_ack = 1'b0;
    tick;
    total++;
    if (ctl !== V_MWRW) $display("FAIL rm_memwr got %b exp %b", ctl, V_MWRW);
    else passed++;
    #2 rst = 1'b0;
    #1;
    total++;
    if ({ctl, instr_count} !== {V_ZERO, 32'd0})
      $display("FAIL rm_async got %b/%0d exp %b/0", ctl, instr_count, V_ZERO);
    else passed++;
    tick;
    mem_ack = 1'b1;
    rst = 1'b1;
    #1;
    total++;
    if (ctl !== V_ZERO) $display("FAIL rm_idle got %b exp %b", ctl, V_ZERO);
    else passed++;
    tick;
    total++;
    if (ctl !== V_FETCH) $display("FAIL rm_fetch got %b exp %b", ctl, V_FETCH);
    else passed++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_rtype(6'b100001, V_ADDU, 1);
    test_rtype(6'b100011, V_SUBU, 2);
    test_lw_wait;
    test_beq(1'b1, V_BEQ1, 4);
    test_beq(1'b0, V_BEQ0, 5);
    test_illegal;
    test_jump_ori;
    test_sw;
    test_timeout;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
